// File: rtl/audio_mix_n.sv
// audio_mix_n: time-multiplexed N-channel audio mixer, one gain MAC per channel per sample strobe.
// Define AUDIO_MIX_DCBLOCK_EN to insert a DC-blocking stage between saturation and output.

module audio_mix_n #(
    parameter int          NUM_CH    = 4,
    parameter int          IN_W      = 16,
    parameter int          OUT_W     = 16,
    parameter logic [15:0] CH_SIGNED = 16'b1110,
    parameter int          ACC_W     = IN_W + 4 + $clog2(NUM_CH)
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ce_sample,
    input  logic [NUM_CH*IN_W-1:0] ch_in,
    input  logic [NUM_CH*4-1:0]    ch_gain,
    output logic [OUT_W-1:0]       out_sample,
    output logic                   out_valid,
    output logic                   clip,
    output logic                   overrun,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_SAT,
        S_DC,
        S_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [NUM_CH*IN_W-1:0]    snap_in_q, snap_in_d;
    logic [NUM_CH*4-1:0]       snap_gain_q, snap_gain_d;
    logic [OUT_W-1:0]          out_sample_q, out_sample_d;
    logic                      out_valid_q, out_valid_d;
    logic                      clip_q, clip_d;
    logic                      overrun_q, overrun_d;

    logic signed [IN_W-1:0]    operand;
    logic [4:0]                gain5;
    logic signed [IN_W+4:0]    prod;
    logic signed [ACC_W-1:0]   scaled;
    logic [OUT_W-1:0]          sat_val;
    logic                      sat_ovf;

`ifdef AUDIO_MIX_DCBLOCK_EN
    localparam int DC_W = OUT_W + 2;
    localparam logic signed [DC_W-1:0] DC_MAX = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic signed [DC_W-1:0] DC_MIN = {3'b111, {(OUT_W-1){1'b0}}};

    logic signed [OUT_W-1:0]   dc_x_q, dc_x_d;
    logic signed [OUT_W-1:0]   x_prev_q, x_prev_d;
    logic signed [OUT_W-1:0]   y_prev_q, y_prev_d;
    logic                      sat_clip_q, sat_clip_d;
    logic signed [DC_W-1:0]    dc_sum;
    logic [OUT_W-1:0]          dc_val;
    logic                      dc_ovf;
`endif

    // Datapath: current channel's MAC term and the saturation of the finished sum.
    always_comb begin
        operand = snap_in_q[idx_q*IN_W +: IN_W];
        if (!CH_SIGNED[idx_q]) begin
            operand[IN_W-1] = ~operand[IN_W-1];
        end
        gain5  = {1'b0, snap_gain_q[idx_q*4 +: 4]};
        prod   = operand * $signed(gain5);
        scaled = acc_q >>> 3;

        sat_val = scaled[OUT_W-1:0];
        sat_ovf = 1'b0;
        if (scaled > SAT_MAX) begin
            sat_val = OUT_MAX;
            sat_ovf = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sat_val = OUT_MIN;
            sat_ovf = 1'b1;
        end
    end

`ifdef AUDIO_MIX_DCBLOCK_EN
    always_comb begin
        dc_sum = DC_W'(dc_x_q) - DC_W'(x_prev_q) + DC_W'(y_prev_q) - DC_W'(y_prev_q >>> 8);
        dc_val = dc_sum[OUT_W-1:0];
        dc_ovf = 1'b0;
        if (dc_sum > DC_MAX) begin
            dc_val = OUT_MAX;
            dc_ovf = 1'b1;
        end else if (dc_sum < DC_MIN) begin
            dc_val = OUT_MIN;
            dc_ovf = 1'b1;
        end
    end
`endif

    // NOTE: every next-state signal gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        snap_in_d    = snap_in_q;
        snap_gain_d  = snap_gain_q;
        out_sample_d = out_sample_q;
        out_valid_d  = 1'b0;
        clip_d       = 1'b0;
        overrun_d    = overrun_q;
`ifdef AUDIO_MIX_DCBLOCK_EN
        dc_x_d       = dc_x_q;
        x_prev_d     = x_prev_q;
        y_prev_d     = y_prev_q;
        sat_clip_d   = sat_clip_q;
`endif

        case (state_q)
            S_IDLE: ;
            S_ACCUM: begin
                acc_d = acc_q + ACC_W'(prod);
                if (idx_q == LAST_IDX) begin
                    state_d = S_SAT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_SAT: begin
`ifdef AUDIO_MIX_DCBLOCK_EN
                dc_x_d     = sat_val;
                sat_clip_d = sat_ovf;
                state_d    = S_DC;
`else
                out_sample_d = sat_val;
                clip_d       = sat_ovf;
                out_valid_d  = 1'b1;
                state_d      = S_OUT;
`endif
            end
`ifdef AUDIO_MIX_DCBLOCK_EN
            S_DC: begin
                x_prev_d     = dc_x_q;
                y_prev_d     = dc_val;
                out_sample_d = dc_val;
                clip_d       = sat_clip_q | dc_ovf;
                out_valid_d  = 1'b1;
                state_d      = S_OUT;
            end
`endif
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The OUT cycle is the last of a sample, so a strobe there starts the next one.
        if (ce_sample) begin
            if (state_q == S_IDLE || state_q == S_OUT) begin
                snap_in_d   = ch_in;
                snap_gain_d = ch_gain;
                acc_d       = '0;
                idx_d       = '0;
                state_d     = S_ACCUM;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the snapshot registers are reset too so no X ever reaches the datapath.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            snap_in_q    <= '0;
            snap_gain_q  <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            clip_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            snap_in_q    <= snap_in_d;
            snap_gain_q  <= snap_gain_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            clip_q       <= clip_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef AUDIO_MIX_DCBLOCK_EN
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dc_x_q     <= '0;
            x_prev_q   <= '0;
            y_prev_q   <= '0;
            sat_clip_q <= 1'b0;
        end else begin
            dc_x_q     <= dc_x_d;
            x_prev_q   <= x_prev_d;
            y_prev_q   <= y_prev_d;
            sat_clip_q <= sat_clip_d;
        end
    end
`endif

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign clip       = clip_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_audio_mix_n.sv
// tb_audio_mix_n: scoreboard bench for audio_mix_n (4 channels, 16-bit, CH_SIGNED=1110, no DC stage).
// Stimulus pushes expected {sample, clip, cycle}; a negedge monitor pops and compares on out_valid.

module tb_audio_mix_n;

    localparam int          NUM_CH    = 4;
    localparam int          IN_W      = 16;
    localparam int          OUT_W     = 16;
    localparam logic [15:0] CH_SIGNED = 16'b1110;
    localparam int          LAT       = NUM_CH + 2;

    logic                   clk_sys   = 1'b0;
    logic                   reset_n   = 1'b0;
    logic                   ce_sample = 1'b0;
    logic [NUM_CH*IN_W-1:0] ch_in     = '0;
    logic [NUM_CH*4-1:0]    ch_gain   = '0;
    logic [OUT_W-1:0]       out_sample;
    logic                   out_valid;
    logic                   clip;
    logic                   overrun;
    logic                   busy;

    audio_mix_n #(
        .NUM_CH   (NUM_CH),
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .CH_SIGNED(CH_SIGNED)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce_sample (ce_sample),
        .ch_in     (ch_in),
        .ch_gain   (ch_gain),
        .out_sample(out_sample),
        .out_valid (out_valid),
        .clip      (clip),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] sample;
        logic        clip;
        int          cycle;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: offset-binary channels are decoded by subtracting midscale.
    function automatic logic [16:0] ref_mix(input logic [63:0] ins, input logic [15:0] gains);
        longint      acc;
        longint      v;
        longint      scaled;
        logic [15:0] s;
        logic [15:0] res;
        logic        c;
        acc = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            s = ins[k*16 +: 16];
            if (CH_SIGNED[k]) v = longint'($signed(s));
            else              v = longint'(s) - 32768;
            acc += v * longint'(gains[k*4 +: 4]);
        end
        scaled = acc >>> 3;
        c = 1'b0;
        if (scaled > 32767) begin
            res = 16'h7FFF;
            c   = 1'b1;
        end else if (scaled < -32768) begin
            res = 16'h8000;
            c   = 1'b1;
        end else begin
            res = scaled[15:0];
        end
        return {c, res};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic strobe(input logic [63:0] ins, input logic [15:0] gains, input bit push,
                          input logic [15:0] exp_sample, input logic exp_clip);
        exp_t e;
        ch_in     = ins;
        ch_gain   = gains;
        ce_sample = 1'b1;
        if (push) begin
            e.sample = exp_sample;
            e.clip   = exp_clip;
            e.cycle  = cyc + LAT;
            sb_q.push_back(e);
        end
        tick(1);
        ce_sample = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 50) begin
            tick(1);
            k++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_sample"}, out_sample, 0);
        check({tag, "_out_valid"},  out_valid,  0);
        check({tag, "_clip"},       clip,       0);
        check({tag, "_overrun"},    overrun,    0);
        check({tag, "_busy"},       busy,       0);
    endtask

    task automatic run_unsigned_midscale(input string tag);
        check({tag, "_busy_before"}, busy, 0);
        strobe({16'h0000, 16'h0000, 16'h0000, 16'h8000}, 16'h8888, 1'b1, 16'h0000, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_sys);
            check({tag, "_busy_window"}, busy, (k <= LAT) ? 1 : 0);
        end
        tick(1);
    endtask

    // Monitor: every out_valid must match the oldest pending expectation, at its cycle.
    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: out_sample %0h with nothing pending (cycle %0d)",
                             out_sample, cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_sample", out_sample, e.sample);
                    check("clip",       clip,       e.clip);
                    check("valid_cycle", cyc,       e.cycle);
                end
            end else if (clip !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL clip_without_valid: clip %b expected 0 (cycle %0d)", clip, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] r;

        reset_n = 1'b0;
        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick(2);

        // Unsigned midscale on ch0 mixes to zero; busy spans T+1..T+6.
        run_unsigned_midscale("s1");

        // Signed mix with mute on ch0: (4096*8 - 4096*4) >>> 3 = 2048.
        strobe({16'h0000, 16'hF000, 16'h1000, 16'h1234}, 16'h0480, 1'b1, 16'h0800, 1'b0);
        wait_idle();

        // Positive and negative saturation.
        strobe({16'h7000, 16'h7000, 16'h7000, 16'h8000}, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1);
        wait_idle();
        strobe({16'h9000, 16'h9000, 16'h9000, 16'h8000}, 16'hFFFF, 1'b1, 16'h8000, 1'b1);
        wait_idle();

        // Exact full-scale values pass without clipping.
        strobe({16'h0000, 16'h0000, 16'h7FFF, 16'h8000}, 16'h0080, 1'b1, 16'h7FFF, 1'b0);
        wait_idle();
        strobe({16'h0000, 16'h0000, 16'h8000, 16'h8000}, 16'h0080, 1'b1, 16'h8000, 1'b0);
        wait_idle();
        // Unsigned zero code is negative full scale.
        strobe({16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0008, 1'b1, 16'h8000, 1'b0);
        wait_idle();
        // -1 * 1 >>> 3 rounds toward minus infinity.
        strobe({16'hFFFF, 16'h0000, 16'h0000, 16'h8000}, 16'h1000, 1'b1, 16'hFFFF, 1'b0);
        wait_idle();
        // All gains zero.
        strobe({16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF}, 16'h0000, 1'b1, 16'h0000, 1'b0);
        wait_idle();
        tick(2);

        // Strobe while busy is ignored and sets sticky overrun.
        check("s4_overrun_before", overrun, 0);
        strobe({16'h0000, 16'hF000, 16'h1000, 16'h8000}, 16'h0480, 1'b1, 16'h0800, 1'b0);
        ch_in = {16'h7000, 16'h7000, 16'h7000, 16'h8000};
        tick(2);
        strobe({16'h7000, 16'h7000, 16'h7000, 16'h8000}, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
        wait_idle();
        tick(3);
        check("s4_overrun_set", overrun, 1);
        check("s4_pending", sb_q.size(), 0);
        tick(10);
        check("s4_overrun_sticky", overrun, 1);
        reset_n = 1'b0;
        tick(1);
        check("s4_overrun_reset", overrun, 0);
        reset_n = 1'b1;
        tick(2);

        // Back-to-back strobes every NUM_CH+2 cycles with inputs changing every cycle.
        for (int s = 0; s < 20; s++) begin
            logic [63:0] ins;
            logic [15:0] gains;
            ins   = {$urandom, $urandom};
            gains = 16'($urandom);
            r     = ref_mix(ins, gains);
            strobe(ins, gains, 1'b1, r[15:0], r[16]);
            repeat (LAT - 1) begin
                ch_in   = {$urandom, $urandom};
                ch_gain = 16'($urandom);
                tick(1);
            end
        end
        wait_idle();
        tick(2);
        check("s5_overrun", overrun, 0);
        check("s5_pending", sb_q.size(), 0);

        // Reset mid-sample aborts it; everything reads zero after the reset edge.
        strobe({16'h0000, 16'hF000, 16'h1000, 16'h8000}, 16'h0480, 1'b0, 16'h0000, 1'b0);
        ce_sample = 1'b1;
        tick(1);
        ce_sample = 1'b0;
        check("s6_overrun_pre", overrun, 1);
        reset_n = 1'b0;
        tick(1);
        check_all_zero("s6_after_reset");
        reset_n = 1'b1;
        tick(12);
        run_unsigned_midscale("s6_restart");

        wait_idle();
        tick(3);
        check("final_pending", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
